// File: rtl/nibble_serial_alu.sv
// Nibble-serial ALU: ADD/SUB/AND/XOR on W=4*NIBBLES bit operands, one 4-bit slice per cycle,
// LSB first, with the slice propagate/generate terms exported for a carry-lookahead stage.
module nibble_serial_alu #(
   parameter  int NIBBLES = 4,
   localparam int W       = 4 * NIBBLES,
   localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [W-1:0]     a,
   input  logic [W-1:0]     b,
   output logic             ready,
   output logic             busy,
   output logic             done,
   output logic [W-1:0]     result,
   output logic             carry_out,
   output logic             zero,
   output logic             overflow,
   output logic [3:0]       slice_p,
   output logic [3:0]       slice_g,
   output logic [IDX_W-1:0] slice_idx
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_AND = 2'b10;

   state_t           state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [W-1:0]     result_q, result_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;
   logic [W-1:0]     a_q, a_d;
   logic [W-1:0]     bx_q, bx_d;
   logic [1:0]       op_q, op_d;
   logic             carry_q, carry_d;
   logic [W-1:0]     shadow_q, shadow_d;

   logic [3:0] a_sl, b_sl, p_sl, g_sl, sum_sl, res_sl;
   logic [4:0] chain;
   logic       arith, last;

   // Slice select and 4-bit ripple through the p/g terms
   always_comb begin
      a_sl = 4'h0;
      b_sl = 4'h0;
      for (int i = 0; i < NIBBLES; i++) begin
         if (idx_q == IDX_W'(i)) begin
            a_sl = a_q[4*i +: 4];
            b_sl = bx_q[4*i +: 4];
         end
      end
      p_sl     = a_sl | b_sl;
      g_sl     = a_sl & b_sl;
      chain    = 5'b0;
      chain[0] = carry_q;
      for (int k = 0; k < 4; k++) begin
         chain[k+1] = g_sl[k] | (p_sl[k] & chain[k]);
      end
      sum_sl = a_sl ^ b_sl ^ chain[3:0];
      arith  = ~op_q[1];
      last   = (idx_q == IDX_W'(NIBBLES - 1));
      case (op_q)
         OP_AND:  res_sl = a_sl & b_sl;
         2'b11:   res_sl = a_sl ^ b_sl;
         default: res_sl = sum_sl;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      result_d = result_q;
      cout_d   = cout_q;
      ovf_d    = ovf_q;
      a_d      = a_q;
      bx_d     = bx_q;
      op_d     = op_q;
      carry_d  = carry_q;
      shadow_d = shadow_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d = S_RUN;
               a_d     = a;
               bx_d    = (op == OP_SUB) ? ~b : b;
               op_d    = op;
               carry_d = (op == OP_SUB);
               idx_d   = '0;
            end else if (state_q == S_DONE) begin
               state_d = S_IDLE;
            end
         end
         S_RUN: begin
            for (int i = 0; i < NIBBLES; i++) begin
               if (idx_q == IDX_W'(i)) shadow_d[4*i +: 4] = res_sl;
            end
            if (arith) carry_d = chain[4];
            if (last) begin
               // Result and flags publish together on entry to DONE
               state_d  = S_DONE;
               idx_d    = '0;
               result_d = shadow_d;
               cout_d   = arith & chain[4];
               ovf_d    = arith & (a_q[W-1] == bx_q[W-1]) & (res_sl[3] != a_q[W-1]);
            end else begin
               idx_d = idx_q + IDX_W'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         idx_q    <= '0;
         result_q <= '0;
         cout_q   <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         result_q <= result_d;
         cout_q   <= cout_d;
         ovf_q    <= ovf_d;
      end
   end

   // Operand/working registers are only read in RUN, so they need no reset
   always_ff @(posedge clk) begin
      a_q      <= a_d;
      bx_q     <= bx_d;
      op_q     <= op_d;
      carry_q  <= carry_d;
      shadow_q <= shadow_d;
   end

   assign ready     = (state_q == S_IDLE) || (state_q == S_DONE);
   assign busy      = (state_q == S_RUN);
   assign done      = (state_q == S_DONE);
   assign result    = result_q;
   assign carry_out = cout_q;
   assign overflow  = ovf_q;
   assign zero      = (result_q == '0);
   assign slice_p   = busy ? p_sl : 4'h0;
   assign slice_g   = busy ? g_sl : 4'h0;
   assign slice_idx = idx_q;

endmodule

// File: tb/tb_nibble_serial_alu.sv
// Scoreboard bench for nibble_serial_alu: driver pushes reference-model results, a negedge
// monitor pops and compares on every done pulse and watches slice outputs during RUN.
module tb_nibble_serial_alu;

   localparam int NIBBLES = 4;
   localparam int W       = 4 * NIBBLES;
   localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

   logic             clk, rst_n, start;
   logic [1:0]       op_i;
   logic [W-1:0]     a_i, b_i;
   logic             ready, busy, done, carry_out, zero, overflow;
   logic [W-1:0]     result;
   logic [3:0]       slice_p, slice_g;
   logic [IDX_W-1:0] slice_idx;

   nibble_serial_alu #(.NIBBLES(NIBBLES)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .op(op_i), .a(a_i), .b(b_i),
      .ready(ready), .busy(busy), .done(done), .result(result),
      .carry_out(carry_out), .zero(zero), .overflow(overflow),
      .slice_p(slice_p), .slice_g(slice_g), .slice_idx(slice_idx)
   );

   typedef struct {
      logic [1:0]   op;
      logic [W-1:0] a, b, res;
      logic         co, ov;
      int           acc;
   } exp_t;

   exp_t         q[$];
   int           checks = 0;
   int           passes = 0;
   int           cyc = 0;
   logic [W-1:0] last_res = '0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input longint act, input longint exp);
      checks++;
      if (act == exp) passes++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
   endtask

   task automatic fail_now(input string nm);
      checks++;
      $display("FAIL %s (t=%0t)", nm, $time);
   endtask

   // Reference model: plain integer arithmetic on the whole operands
   function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
      exp_t   e;
      longint ux = x;
      longint uy = y;
      longint sx = $signed(x);
      longint sy = $signed(y);
      longint maxs = (longint'(1) << (W - 1)) - 1;
      longint mins = -(longint'(1) << (W - 1));
      longint r, sr;
      e.op = o; e.a = x; e.b = y; e.co = 1'b0; e.ov = 1'b0; e.acc = 0;
      case (o)
         2'b00: begin
            r = ux + uy;  e.res = r[W-1:0];  e.co = (r >= (longint'(1) << W));
            sr = sx + sy; e.ov = (sr > maxs) || (sr < mins);
         end
         2'b01: begin
            r = ux - uy;  e.res = r[W-1:0];  e.co = (ux >= uy);
            sr = sx - sy; e.ov = (sr > maxs) || (sr < mins);
         end
         2'b10:   e.res = x & y;
         default: e.res = x ^ y;
      endcase
      return e;
   endfunction

   task automatic chk_reset_vals();
      chk("rst_ready", ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_result", result, 0);
      chk("rst_carry", carry_out, 0);
      chk("rst_zero", zero, 1);
      chk("rst_ovf", overflow, 0);
      chk("rst_p", slice_p, 0);
      chk("rst_g", slice_g, 0);
      chk("rst_idx", slice_idx, 0);
   endtask

   // Monitor
   always @(negedge clk) begin
      exp_t         e;
      logic [W-1:0] bx, sa, sb;
      int           idx;
      cyc++;
      if (rst_n) begin
         chk("ready_vs_busy", ready, !busy);
         if (!busy) begin
            chk("p_idle", slice_p, 0);
            chk("g_idle", slice_g, 0);
         end else if (q.size() == 0) begin
            fail_now("busy_without_op");
         end else begin
            e   = q[0];
            idx = cyc - e.acc - 1;
            chk("slice_idx", slice_idx, idx);
            if (idx >= 0 && idx < NIBBLES) begin
               bx = (e.op == 2'b01) ? ~e.b : e.b;
               sa = e.a >> (4 * idx);
               sb = bx >> (4 * idx);
               chk("slice_p", slice_p, (sa[3:0] | sb[3:0]));
               chk("slice_g", slice_g, (sa[3:0] & sb[3:0]));
            end
            chk("result_hold", result, last_res);
         end
         if (done) begin
            if (q.size() == 0) begin
               fail_now("done_without_op");
            end else begin
               e = q.pop_front();
               chk("latency", cyc, e.acc + 1 + NIBBLES);
               chk("result", result, e.res);
               chk("carry_out", carry_out, e.co);
               chk("overflow", overflow, e.ov);
               chk("zero", zero, (e.res == '0));
               chk("idx_wrap", slice_idx, 0);
            end
         end
         last_res = result;
      end
   end

   task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y, input bit keep);
      int   n = 0;
      exp_t e;
      @(negedge clk);
      while (!ready && n < 64) begin
         @(negedge clk);
         n++;
      end
      if (!ready) begin
         fail_now("ready_timeout");
         return;
      end
      op_i = o; a_i = x; b_i = y; start = 1'b1;
      @(posedge clk);
      e = model(o, x, y);
      e.acc = cyc;
      q.push_back(e);
      #1;
      if (!keep) start = 1'b0;
   endtask

   // Scrambles operands during RUN; without keep, also injects a stray start pulse
   task automatic noise(input bit keep);
      for (int k = 0; k < NIBBLES - 1; k++) begin
         @(negedge clk);
         a_i  = W'($urandom);
         b_i  = W'($urandom);
         op_i = 2'($urandom);
         if (!keep) start = (k == 1) ? 1'($urandom) : 1'b0;
      end
      if (!keep) start = 1'b0;
   endtask

   initial begin
      int n;
      rst_n = 1'b0; start = 1'b0; op_i = 2'b00; a_i = '0; b_i = '0;
      #3;
      chk_reset_vals();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      issue(2'b00, 16'h00FF, 16'h0001, 0);
      issue(2'b00, 16'hFFFF, 16'h0001, 0);
      issue(2'b00, 16'h7FFF, 16'h0001, 0);
      issue(2'b01, 16'h0003, 16'h0005, 0);
      issue(2'b01, 16'h8000, 16'h0001, 0);
      issue(2'b10, 16'hF0F0, 16'h0FF0, 0);
      issue(2'b11, 16'hA5C3, 16'hA5C3, 0);
      issue(2'b01, 16'h1234, 16'h1234, 0);

      // Back-to-back with operand toggling, then stray start pulses during RUN
      issue(2'b00, 16'h1357, 16'h2468, 1);
      noise(1);
      issue(2'b01, 16'h0100, 16'h0200, 0);
      noise(0);
      issue(2'b11, 16'hFFFF, 16'h0F0F, 0);

      // Reset in the 2nd RUN cycle aborts the operation
      issue(2'b00, 16'h4321, 16'h1111, 0);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      q.delete();
      #1;
      chk_reset_vals();
      @(negedge clk);
      chk_reset_vals();
      @(negedge clk);
      rst_n = 1'b1;
      issue(2'b00, 16'h1111, 16'h2222, 0);

      for (int i = 0; i < 150; i++) begin
         bit keep;
         keep = ($urandom_range(0, 3) == 0);
         issue(2'($urandom), W'($urandom), W'($urandom), keep);
         noise(keep);
      end
      start = 1'b0;

      n = 0;
      while (q.size() != 0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (q.size() != 0) fail_now("drain_timeout");
      repeat (3) @(negedge clk);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
